cdb_arbiter: RTL

- Arbitrates the single Common Data Bus (CDB) between the two result producers: the ALU behind the ReservationStation, and the LoadStoreBuffer load/store completion path.
- Each source has a small in-order queue that absorbs collisions.
- A round-robin grant picks one entry per cycle and drives a registered broadcast to ReorderBuffer, ReservationStation and LoadStoreBuffer.
- A ROB flush discards everything in flight.

---
 rtl/cdb_arbiter_pkg.sv | 10 +
 rtl/cdb_src_queue.sv | 57 +++++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: source encodings and default sizes.
package cdb_arbiter_pkg;

  localparam int CDB_ROB_WIDTH_BIT = 5;
  localparam int CDB_QUEUE_DEPTH   = 2;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

endpackage

// File: rtl/cdb_src_queue.sv
// Small in-order FIFO holding {rob_id, value} results for one CDB source.
module cdb_src_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rdy,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // A full queue refuses pushes even when it pops in the same cycle.
  assign w_do_push = i_rdy && !i_clear && i_push && !o_full;
  assign w_do_pop  = i_rdy && !i_clear && i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_rdy && i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_tail] <= i_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the Common Data Bus between the ALU and LSB result paths.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH   = CDB_QUEUE_DEPTH,
  parameter int ROB_WIDTH_BIT = CDB_ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     alu_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_value,
  output logic                     alu_ready,
  input  logic                     lsb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  output logic                     lsb_ready,
  output logic                     cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  output logic [31:0]              cdb_value
);

  localparam int EW = ROB_WIDTH_BIT + 32;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [EW-1:0] w_alu_head;
  logic [EW-1:0] w_lsb_head;
  logic          w_alu_empty;
  logic          w_lsb_empty;
  logic          w_alu_full;
  logic          w_lsb_full;
  logic [CW-1:0] w_alu_count;
  logic [CW-1:0] w_lsb_count;
  logic          w_alu_push;
  logic          w_lsb_push;
  logic          w_grant_alu;
  logic          w_grant_lsb;
  logic          w_contend;
  logic          w_unused;
  logic          r_last_grant;

  assign alu_ready  = rdy_in && !flush && (w_alu_count < CW'(QUEUE_DEPTH));
  assign lsb_ready  = rdy_in && !flush && (w_lsb_count < CW'(QUEUE_DEPTH));
  assign w_alu_push = alu_valid && alu_ready;
  assign w_lsb_push = lsb_valid && lsb_ready;
  assign w_unused   = w_alu_full ^ w_lsb_full;

  cdb_src_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_alu_q (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_rdy   (rdy_in),
    .i_push  (w_alu_push),
    .i_pop   (w_grant_alu),
    .i_clear (flush),
    .i_data  ({alu_rob_id, alu_value}),
    .o_head  (w_alu_head),
    .o_empty (w_alu_empty),
    .o_full  (w_alu_full),
    .o_count (w_alu_count)
  );

  cdb_src_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_lsb_q (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_rdy   (rdy_in),
    .i_push  (w_lsb_push),
    .i_pop   (w_grant_lsb),
    .i_clear (flush),
    .i_data  ({lsb_rob_id, lsb_value}),
    .o_head  (w_lsb_head),
    .o_empty (w_lsb_empty),
    .o_full  (w_lsb_full),
    .o_count (w_lsb_count)
  );

  // last_grant only moves on contention, so alternation applies to ties alone.
  assign w_contend   = !w_alu_empty && !w_lsb_empty;
  assign w_grant_alu = !w_alu_empty && (w_lsb_empty || (r_last_grant == CDB_SRC_LSB));
  assign w_grant_lsb = !w_lsb_empty && !w_grant_alu;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid    <= 1'b0;
      cdb_rob_id   <= '0;
      cdb_value    <= '0;
      r_last_grant <= CDB_SRC_LSB;
    end else if (rdy_in) begin
      if (flush) begin
        cdb_valid    <= 1'b0;
        r_last_grant <= CDB_SRC_LSB;
      end else if (w_grant_alu) begin
        cdb_valid                 <= 1'b1;
        {cdb_rob_id, cdb_value}   <= w_alu_head;
        if (w_contend) r_last_grant <= CDB_SRC_ALU;
      end else if (w_grant_lsb) begin
        cdb_valid                 <= 1'b1;
        {cdb_rob_id, cdb_value}   <= w_lsb_head;
        if (w_contend) r_last_grant <= CDB_SRC_LSB;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
